// File: rtl/fifo_rd_burst_unpack_pkg.sv
// Shared types and width helpers for the FWFT-FIFO burst reader / word unpacker.
// The FSM state encoding and lane/width arithmetic live here so RTL and bench agree.
package fifo_rd_burst_unpack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int DEF_DSIZE     = 512;
  localparam int DEF_OSIZE     = 64;
  localparam int DEF_BURST_THR = 8;
  localparam int DEF_BURST_LEN = 16;

  // Read-side occupancy width of the upstream FIFO.
  localparam int RCOUNT_W = 9;

  function automatic int lanes_of(input int dsize, input int osize);
    return dsize / osize;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_burst_unpack_if.sv
// FIFO read port plus beat stream of the burst unpacker, bundled as one interface.
// master = the unpacker's view, slave = the FIFO/consumer environment's view.
interface fifo_rd_burst_unpack_if
  import fifo_rd_burst_unpack_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int OSIZE = DEF_OSIZE
);

  // FIFO read side
  logic [DSIZE-1:0]    dout;
  logic                empty;
  logic [RCOUNT_W-1:0] rcount;
  logic                rd_en;
  logic                flush;

  // Beat stream
  logic [OSIZE-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (
    input  dout, empty, rcount, flush, m_ready,
    output rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output dout, empty, rcount, flush, m_ready,
    input  rd_en, m_data, m_valid, m_last
  );

endinterface

// File: rtl/fifo_rd_burst_unpack.sv
// Pops bursts of words from a first-word-fall-through FIFO and emits each word as
// LANES narrow beats, least-significant lane first, with m_last on the burst's final beat.
module fifo_rd_burst_unpack
  import fifo_rd_burst_unpack_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int OSIZE     = DEF_OSIZE,
  parameter int BURST_THR = DEF_BURST_THR,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  fifo_rd_burst_unpack_if.master bus,
  output logic                   busy
);

  localparam int LANES  = lanes_of(DSIZE, OSIZE);
  localparam int LANE_W = idx_width(LANES);
  localparam int WL_W   = $clog2(BURST_LEN + 1);

  localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
  localparam logic [WL_W-1:0]     ONE_WORD  = WL_W'(1);
  localparam logic [RCOUNT_W-1:0] THR       = RCOUNT_W'(BURST_THR);
  localparam logic [RCOUNT_W-1:0] BLEN      = RCOUNT_W'(BURST_LEN);

  state_t              state, state_nxt;
  logic [LANE_W-1:0]   lane, lane_nxt;
  logic [WL_W-1:0]     words_left, wl_nxt;
  logic [DSIZE-1:0]    hold;

  logic                load_word;
  logic                pop_req;
  logic                shifting;
  logic                handshake;
  logic                at_last_lane;
  logic                final_word;
  logic                start_burst;
  logic [RCOUNT_W-1:0] rc_clip;
  logic [WL_W-1:0]     burst_words;

  // Reset gates every output so nothing leaks out during the reset cycle itself.
  assign shifting     = (state == ST_SHIFT) && !rd_rst;
  assign handshake    = shifting && bus.m_ready;
  assign at_last_lane = (lane == LAST_LANE);
  assign final_word   = (words_left == ONE_WORD);

  assign start_burst  = (bus.rcount >= THR) || (bus.flush && !bus.empty);
  assign rc_clip      = (bus.rcount > BLEN) ? BLEN : bus.rcount;
  // A flush with rcount still reading 0 must still move at least the visible head word.
  assign burst_words  = (rc_clip == '0) ? ONE_WORD : WL_W'(rc_clip);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    wl_nxt    = words_left;
    load_word = 1'b0;
    pop_req   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start_burst) begin
          state_nxt = ST_LOAD;
          wl_nxt    = burst_words;
        end
      end

      ST_LOAD: begin
        if (!bus.empty) begin
          load_word = 1'b1;
          pop_req   = 1'b1;
          lane_nxt  = '0;
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (handshake) begin
          if (!at_last_lane) begin
            lane_nxt = lane + LANE_ONE;
          end else begin
            lane_nxt = '0;
            wl_nxt   = words_left - ONE_WORD;
            if (final_word) begin
              state_nxt = ST_IDLE;
            end else if (!bus.empty) begin
              // Refill in the same cycle as the last lane drains: no bubble.
              load_word = 1'b1;
              pop_req   = 1'b1;
            end else begin
              state_nxt = ST_LOAD;
            end
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state      <= ST_IDLE;
      lane       <= '0;
      words_left <= '0;
    end else begin
      state      <= state_nxt;
      lane       <= lane_nxt;
      words_left <= wl_nxt;
    end
  end

  // NOTE: the wide hold register carries no reset; m_data is forced to zero
  // outside SHIFT and every burst reloads it before its first beat.
  always_ff @(posedge rd_clk) begin
    if (load_word && !rd_rst) begin
      hold <= bus.dout;
    end
  end

  assign bus.rd_en   = pop_req && !bus.empty && !rd_rst;
  assign bus.m_valid = shifting;
  assign bus.m_last  = shifting && at_last_lane && final_word;
  assign bus.m_data  = shifting ? hold[int'(lane)*OSIZE +: OSIZE] : '0;
  assign busy        = (state != ST_IDLE) && !rd_rst;

endmodule
